// File: rtl/bp_error_accumulator_pkg.sv
// Shared definitions for the back-propagation error accumulator.
//   NUM_INPUTS_DEFAULT : default vector length (dendrites per neuron)
//   bp_vec_t           : one backprop-change vector of reals
//   acc_state_t        : accumulator control states
package bp_error_accumulator_pkg;

  localparam int NUM_INPUTS_DEFAULT = 32;
  localparam int NUM_INPUTS         = NUM_INPUTS_DEFAULT;

  typedef real bp_vec_t [NUM_INPUTS];

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage

// File: rtl/bp_error_accumulator_lane.sv
// One element of the summed error vector: a single real accumulator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : acc <= 0.0
//   load       : acc <= din (starts a new batch with its first vector)
//   add        : acc <= acc + din
//   din        : incoming change value for this dendrite
//   acc        : current accumulated value
// Priority when several controls are high: clear, load, add.
module bp_acc_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic add,
  input  real  din,
  output real  acc
);

  // Accumulator register with clear/load/add controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 0.0;
    end else if (clear) begin
      acc <= 0.0;
    end else if (load) begin
      acc <= din;
    end else if (add) begin
      acc <= acc + din;
    end else begin
      acc <= acc;
    end
  end

endmodule

// File: rtl/bp_error_accumulator.sv
// Sums NUM_NEURONS backprop-change vectors element-wise and presents the
// result as the error input vector for the previous layer.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : input handshake, in_change is one neuron's vector
//   flush               : discard a partial batch (ignored while a result waits)
//   out_valid/out_ready : output handshake, out_sum is the completed batch sum
//   count               : vectors accepted in the current batch
module bp_error_accumulator
  import bp_error_accumulator_pkg::*;
#(
  parameter int NUM_INPUTS  = 32,
  parameter int NUM_NEURONS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  real        in_change [NUM_INPUTS],
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output real        out_sum [NUM_INPUTS],
  output logic [7:0] count
);

  localparam logic [7:0] NN_L     = 8'(NUM_NEURONS);
  localparam logic       SINGLE_L = (NUM_NEURONS == 1) ? 1'b1 : 1'b0;

  acc_state_t state_r, state_nxt_s;
  logic [7:0] count_r, count_nxt_s;
  logic       accept_s, xfer_s;
  logic       clear_s, load_s, add_s;

  // While a result waits, a new vector may only enter in the cycle the result
  // leaves, so the next batch can start with no bubble.
  assign in_ready  = (state_r == HOLD) ? out_ready : ~flush;
  assign out_valid = (state_r == HOLD);
  assign count     = count_r;
  assign accept_s  = in_valid & in_ready;
  assign xfer_s    = out_valid & out_ready;

  // State and batch counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ACCUM;
      count_r <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Next-state, counter and lane control decode.
  always_comb begin
    state_nxt_s = state_r;
    count_nxt_s = count_r;
    clear_s     = 1'b0;
    load_s      = 1'b0;
    add_s       = 1'b0;
    case (state_r)
      ACCUM: begin
        if (flush) begin
          clear_s     = 1'b1;
          count_nxt_s = 8'd0;
        end else if (accept_s) begin
          add_s       = 1'b1;
          count_nxt_s = count_r + 8'd1;
          if (count_r == (NN_L - 8'd1)) begin
            state_nxt_s = HOLD;
          end else begin
            state_nxt_s = ACCUM;
          end
        end else begin
          count_nxt_s = count_r;
        end
      end
      HOLD: begin
        if (xfer_s) begin
          if (accept_s) begin
            // The accepted vector becomes the first term of the next batch;
            // with a single-neuron batch it is already a complete result.
            load_s      = 1'b1;
            count_nxt_s = 8'd1;
            state_nxt_s = SINGLE_L ? HOLD : ACCUM;
          end else begin
            clear_s     = 1'b1;
            count_nxt_s = 8'd0;
            state_nxt_s = ACCUM;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        clear_s     = 1'b1;
        count_nxt_s = 8'd0;
        state_nxt_s = ACCUM;
      end
    endcase
  end

  // One accumulator lane per dendrite; lane registers drive out_sum directly.
  for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_lane
    bp_acc_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear_s),
      .load  (load_s),
      .add   (add_s),
      .din   (in_change[g]),
      .acc   (out_sum[g])
    );
  end

endmodule

// File: doc/bp_error_accumulator.md
Name: bp_error_accumulator

Overview:
- Downstream of the per-neuron back-propagation stage.
- Each neuron in a layer produces a 32-entry backprop-change vector, one entry per dendrite. This block sums those vectors element-wise across all NUM_NEURONS neurons of the layer.
- It then presents the summed vector as the bp_backprop error inputs for the previous layer.
- Vectors arrive serially over a valid/ready handshake; the result leaves over a second valid/ready handshake.

Parameters:
- NUM_INPUTS, 32, vector length (dendrites per neuron).
- NUM_NEURONS, 8, vectors per batch (neurons in the layer); legal range 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_change holds a valid vector.
- in_ready  out  1  block accepts in_change this cycle.
- in_change  in  real[NUM_INPUTS]  one neuron's backprop-change vector.
- flush  in  1  discard the partial batch.
- out_valid  out  1  out_sum holds a completed batch.
- out_ready  in  1  consumer takes out_sum this cycle.
- out_sum  out  real[NUM_INPUTS]  element-wise sum of the batch.
- count  out  8  vectors accepted in the current batch.

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - state=ACCUM, every sum entry=0.0, count=0;
  - out_valid=0, in_ready=1.
  - Reset mid-batch or mid-HOLD drops all data with no output.
- Input acceptance: accept = in_valid && in_ready.
- Output transfer: xfer = out_valid && out_ready.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - On accept: sum[i] <= sum[i] + in_change[i] for all i, and count <= count+1.
  - If the accept makes count reach NUM_NEURONS, go to HOLD on the next edge.
- State HOLD:
  - out_valid=1, out_sum=sum, count=NUM_NEURONS.
  - in_ready = out_ready (bypass: the next batch may start in the same cycle the result is taken).
  - On xfer without accept: sum <= 0.0, count <= 0, go to ACCUM.
  - On xfer with accept: sum[i] <= in_change[i], count <= 1, go to ACCUM. If NUM_NEURONS=1, go to HOLD instead.
  - Without xfer: out_sum and count are held stable. out_sum must not change while out_valid=1 and out_ready=0.
- flush:
  - In ACCUM, flush has priority over accept: sum <= 0.0, count <= 0, and the in_change vector present that cycle is not accepted. in_ready is forced 0 while flush=1.
  - flush is ignored in HOLD; a completed batch is never discarded.
- Latency:
  - out_valid rises on the edge after the accept of the final vector.
  - Back-to-back batches need no idle cycles in either state.
- Arithmetic:
  - real addition in accept order, entry 0 through NUM_INPUTS-1 independently.
  - No scaling or averaging.
  - The threshold weight has no upstream error term and is not carried.
- count is 8 bits and never wraps; NUM_NEURONS is limited to 255.

Decomposition:
- Shared package holds:
  - NUM_INPUTS_DEFAULT=32;
  - typedef real bp_vec_t[NUM_INPUTS];
  - enum acc_state_t {ACCUM, HOLD}.
- One sub-module, bp_acc_lane: a single real accumulator register with load/add/clear controls.
  - The top instantiates NUM_INPUTS lanes via generate.
  - The FSM and counter live in the top.

Test Plan:
- Basic batch:
  - Stimulus: reset, then 8 consecutive vectors with in_change[i]=1.0 (in_valid held high), out_ready=1.
  - Required: out_valid=1 exactly one cycle after the 8th accept; out_sum[i]=8.0 for all i; count=8.
- Signed values:
  - Stimulus: vectors k=0..7 with in_change[i]=(k-3.5)*0.5.
  - Required: out_sum[i]=0.0.
  - Stimulus: vector in_change[5]=-2.25 on all 8 neurons, other entries 0.
  - Required: out_sum[5]=-18.0, all other entries 0.0.
- Backpressure:
  - Stimulus: complete a batch, hold out_ready=0 for 5 cycles while in_valid=1.
  - Required: in_ready=0 and out_sum stable for all 5 cycles; no vector accepted.
  - Stimulus: raise out_ready in the same cycle as a vector of all 3.0.
  - Required: xfer occurs and the new batch starts with sum=3.0, count=1.
- Flush:
  - Stimulus: accept 3 vectors of 2.0, then assert flush with in_valid=1 for one cycle, then send 8 vectors of 1.0.
  - Required: count=0 after the flush; result out_sum=8.0, not 14.0.
- Reset mid-operation:
  - Stimulus: accept 4 vectors, then pulse rst_n=0 asynchronously between clock edges.
  - Required: out_valid=0 and count=0 immediately, without waiting for a clock edge; the following 8-vector batch of 1.0 yields 8.0.
- NUM_NEURONS=1 instance:
  - Stimulus: continuous in_valid with out_ready=1.
  - Required: one vector accepted every cycle; out_valid=1 every cycle from the second cycle onward; each out_sum equals the previous cycle's input.
